// File: rtl/step_decoder_pkg.sv
// Shared definitions for the one-hot step generator: default code width,
// derived output width and a reference one-hot helper.
package step_decoder_pkg;

  localparam int N_DEFAULT = 3;
  localparam int M_DEFAULT = 1 << N_DEFAULT;

  // One-hot encoding of a binary step code at the default width.
  function automatic logic [M_DEFAULT-1:0] onehot(input logic [N_DEFAULT-1:0] code);
    logic [M_DEFAULT-1:0] v;
    v = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/step_decoder_dec.sv
// Combinational N-to-2^N decoder with enable.
// When enabled, exactly one output line is set; when disabled, all outputs are low.
module dec_n_to_m
  import step_decoder_pkg::*;
#(
  parameter  int N = N_DEFAULT,
  localparam int M = 1 << N
) (
  input  logic         i_en,
  input  logic [N-1:0] i_code,
  output logic [M-1:0] o_y
);

  // Decode the binary code into a single active line, gated by the enable.
  always_comb begin
    // NOTE: assign a default first so that no path leaves o_y unassigned, which would infer a latch.
    o_y = '0;
    if (i_en) begin
      o_y[i_code] = 1'b1;
    end
  end

endmodule

// File: rtl/step_decoder.sv
// Registered one-hot step generator.
// A binary step counter can be cleared, loaded, stepped and wrapped at LAST_STEP.
// The one-hot output drives timing-step or register-enable lines.
// Wrap and Err are single-cycle status pulses.
module step_decoder
  import step_decoder_pkg::*;
#(
  parameter  int N         = N_DEFAULT,
  parameter  int LAST_STEP = (1 << N) - 1,
  localparam int M         = 1 << N
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_en,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [N-1:0] i_w,
  input  logic         i_step,
  output logic [M-1:0] o_y,
  output logic [N-1:0] o_count,
  output logic         o_wrap,
  output logic         o_err
);

  // A LAST_STEP outside the code range has no valid wrap point.
  if (LAST_STEP >= M || LAST_STEP < 0) begin : g_bad_cfg
    $fatal(1, "step_decoder: LAST_STEP must be in 0 .. 2**N-1");
  end

  localparam logic [N-1:0] LAST_CODE = N'(LAST_STEP);

  logic [N-1:0] r_count;
  logic [M-1:0] r_y;
  logic         r_wrap;
  logic         r_err;

  logic [N-1:0] w_count_next;
  logic         w_wrap_next;
  logic         w_err_next;
  logic [M-1:0] w_y_next;

  // Next-count selection with priority Clear > (disabled hold) > Load > Step > hold.
  always_comb begin
    w_count_next = r_count;
    w_wrap_next  = 1'b0;
    w_err_next   = 1'b0;
    if (i_clear) begin
      w_count_next = '0;
    end else if (!i_en) begin
      w_count_next = r_count;
    end else if (i_load) begin
      // An out-of-range load is rejected: the count holds and Err is flagged.
      if (i_w > LAST_CODE) begin
        w_err_next = 1'b1;
      end else begin
        w_count_next = i_w;
      end
    end else if (i_step) begin
      if (r_count == LAST_CODE) begin
        w_count_next = '0;
        w_wrap_next  = 1'b1;
      end else begin
        w_count_next = r_count + N'(1);
      end
    end
  end

  // The one-hot output is decoded from the next count, so Y and Count move together.
  dec_n_to_m #(.N(N)) u_dec (
    .i_en   (i_en),
    .i_code (w_count_next),
    .o_y    (w_y_next)
  );

  // State and output registers, with a synchronous reset that overrides all controls.
  always_ff @(posedge i_clock) begin
    // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
    if (i_reset) begin
      r_count <= '0;
      r_y     <= '0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_y     <= w_y_next;
      r_wrap  <= w_wrap_next;
      r_err   <= w_err_next;
    end
  end

  assign o_y     = r_y;
  assign o_count = r_count;
  assign o_wrap  = r_wrap;
  assign o_err   = r_err;

endmodule
